// File: rtl/noc_ep_pkg.sv
// ============================================================================
// Module      : noc_ep_pkg
// Description : Shared types, flit field positions and the saturating
//               increment used by the NoC traffic endpoint.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package noc_ep_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } tx_state_t;

    localparam int FLIT_IDX_LSB = 0;
    localparam int FLIT_IDX_W   = 16;
    localparam int SEQ_LSB      = 16;
    localparam int SEQ_W        = 16;

    // Counts of up to 32 bits; the caller casts the result back to its width.
    function automatic logic [31:0] sat_inc(input logic [31:0] cnt, input int unsigned width);
        logic [31:0] v_max;
        v_max = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        return (cnt >= v_max) ? cnt : cnt + 32'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/noc_traffic_endpoint_if.sv
// ============================================================================
// Module      : noc_traffic_endpoint_if
// Description : One AXI-Stream channel (tvalid/tready/tdata/tlast/tid/tdest).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface noc_traffic_endpoint_if #(
    parameter int TID_WIDTH   = 2,
    parameter int TDEST_WIDTH = 4,
    parameter int TDATA_WIDTH = 32
);
    logic                   tvalid;
    logic                   tready;
    logic [TDATA_WIDTH-1:0] tdata;
    logic                   tlast;
    logic [TID_WIDTH-1:0]   tid;
    logic [TDEST_WIDTH-1:0] tdest;

    modport master (output tvalid, tdata, tlast, tid, tdest, input tready);
    modport slave  (input tvalid, tdata, tlast, tid, tdest, output tready);

endinterface

`default_nettype wire

// File: rtl/noc_ep_rx_checker.sv
// ============================================================================
// Module      : noc_ep_rx_checker
// Description : RX sink of the traffic endpoint; counts packets and, when
//               NOC_EP_RX_CHECK_EN is defined, checks flit index and tid.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module noc_ep_rx_checker
    import noc_ep_pkg::*;
#(
    parameter int CNT_WIDTH = 16
) (
    input  wire logic               clk_usr,
    input  wire logic               rst_n,
    noc_traffic_endpoint_if.slave   axis_in,
    output logic [CNT_WIDTH-1:0]    rx_pkt_cnt,
    output logic [CNT_WIDTH-1:0]    rx_err_cnt
);

    logic                 r_tready;
    logic [CNT_WIDTH-1:0] r_pkt_cnt;
    logic                 w_hs;

    assign w_hs           = axis_in.tvalid && r_tready;
    assign axis_in.tready = r_tready;
    assign rx_pkt_cnt     = r_pkt_cnt;

    always_ff @(posedge clk_usr or negedge rst_n) begin
        if (!rst_n) begin
            r_tready  <= 1'b0;
            r_pkt_cnt <= '0;
        end else begin
            r_tready <= 1'b1;
            if (w_hs && axis_in.tlast) begin
                r_pkt_cnt <= CNT_WIDTH'(sat_inc(32'(r_pkt_cnt), CNT_WIDTH));
            end
        end
    end

`ifdef NOC_EP_RX_CHECK_EN
    logic [FLIT_IDX_W-1:0]          r_exp_idx;
    logic [FLIT_IDX_W-1:0]          w_rx_idx;
    logic                           r_sop;
    logic [$bits(axis_in.tid)-1:0]  r_tid;
    logic [CNT_WIDTH-1:0]           r_err_cnt;
    logic                           w_bad;
    logic                           w_unused;

    assign w_rx_idx = axis_in.tdata[FLIT_IDX_LSB +: FLIT_IDX_W];
    // One increment per flit even when both the index and the tid are wrong.
    assign w_bad    = (w_rx_idx != r_exp_idx) || (!r_sop && (axis_in.tid != r_tid));

    always_ff @(posedge clk_usr or negedge rst_n) begin
        if (!rst_n) begin
            r_exp_idx <= '0;
            r_sop     <= 1'b1;
            r_tid     <= '0;
            r_err_cnt <= '0;
        end else if (w_hs) begin
            // Following the received index resynchronises after a mismatch.
            r_exp_idx <= axis_in.tlast ? '0 : w_rx_idx + FLIT_IDX_W'(1);
            r_sop     <= axis_in.tlast;
            if (r_sop) begin
                r_tid <= axis_in.tid;
            end
            if (w_bad) begin
                r_err_cnt <= CNT_WIDTH'(sat_inc(32'(r_err_cnt), CNT_WIDTH));
            end
        end
    end

    assign rx_err_cnt = r_err_cnt;
    assign w_unused   = ^{axis_in.tdata, axis_in.tdest};
`else
    logic w_unused;

    assign rx_err_cnt = '0;
    assign w_unused   = ^{axis_in.tdata, axis_in.tid, axis_in.tdest};
`endif

endmodule

`default_nettype wire

// File: rtl/noc_traffic_endpoint.sv
// ============================================================================
// Module      : noc_traffic_endpoint
// Description : NoC traffic endpoint: TX packet generator FSM plus RX sink.
//               Optional RX checking enabled by defining NOC_EP_RX_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module noc_traffic_endpoint
    import noc_ep_pkg::*;
#(
    parameter int TID_WIDTH   = 2,
    parameter int TDEST_WIDTH = 4,
    parameter int TDATA_WIDTH = 32,
    parameter int LEN_WIDTH   = 8,
    parameter int CNT_WIDTH   = 16
) (
    input  wire logic                   clk_usr,
    input  wire logic                   rst_n,
    input  wire logic                   cfg_start,
    input  wire logic                   cfg_stop,
    input  wire logic [TDEST_WIDTH-1:0] cfg_dest,
    input  wire logic [LEN_WIDTH-1:0]   cfg_pkt_len,
    input  wire logic [CNT_WIDTH-1:0]   cfg_num_pkts,
    noc_traffic_endpoint_if.master      axis_out,
    noc_traffic_endpoint_if.slave       axis_in,
    output logic                        busy,
    output logic                        done,
    output logic [CNT_WIDTH-1:0]        tx_pkt_cnt,
    output logic [CNT_WIDTH-1:0]        rx_pkt_cnt,
    output logic [CNT_WIDTH-1:0]        rx_err_cnt
);

    tx_state_t              r_state,      w_state_nxt;
    logic [TDEST_WIDTH-1:0] r_dest,       w_dest_nxt;
    logic [LEN_WIDTH-1:0]   r_len,        w_len_nxt;
    logic [LEN_WIDTH-1:0]   r_flit_idx,   w_idx_nxt;
    logic [CNT_WIDTH-1:0]   r_num,        w_num_nxt;
    logic [CNT_WIDTH-1:0]   r_pkt_seq,    w_seq_nxt;
    logic [CNT_WIDTH-1:0]   r_tx_pkt_cnt, w_cnt_nxt;
    logic                   r_stop_pend,  w_stop_nxt;

    logic                   w_hs;
    logic                   w_last;
    logic                   w_stop_req;
    logic                   w_num_hit;
    logic                   w_send_nxt;
    logic [TDATA_WIDTH-1:0] w_tdata_nxt;

    logic                   r_tvalid;
    logic [TDATA_WIDTH-1:0] r_tdata;
    logic                   r_tlast;
    logic [TID_WIDTH-1:0]   r_tid;
    logic [TDEST_WIDTH-1:0] r_tdest;
    logic                   r_busy;
    logic                   r_done;

    assign w_hs       = (r_state == SEND) && axis_out.tready;
    assign w_last     = (r_flit_idx == (r_len - LEN_WIDTH'(1)));
    assign w_stop_req = cfg_stop && !cfg_start;
    assign w_num_hit  = (r_num != '0) && ((r_tx_pkt_cnt + CNT_WIDTH'(1)) == r_num);

    always_ff @(posedge clk_usr or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_dest_nxt  = r_dest;
        w_len_nxt   = r_len;
        w_num_nxt   = r_num;
        w_idx_nxt   = r_flit_idx;
        w_seq_nxt   = r_pkt_seq;
        w_cnt_nxt   = r_tx_pkt_cnt;
        w_stop_nxt  = r_stop_pend;
        unique case (r_state)
            IDLE, DONE: begin
                if (cfg_start) begin
                    w_state_nxt = SEND;
                    w_dest_nxt  = cfg_dest;
                    w_len_nxt   = (cfg_pkt_len == '0) ? LEN_WIDTH'(1) : cfg_pkt_len;
                    w_num_nxt   = cfg_num_pkts;
                    w_idx_nxt   = '0;
                    w_seq_nxt   = '0;
                    w_cnt_nxt   = '0;
                    w_stop_nxt  = 1'b0;
                end
            end
            SEND: begin
                if (w_stop_req) begin
                    w_stop_nxt = 1'b1;
                end
                if (w_hs) begin
                    if (w_last) begin
                        w_idx_nxt = '0;
                        w_seq_nxt = r_pkt_seq + CNT_WIDTH'(1);
                        w_cnt_nxt = CNT_WIDTH'(sat_inc(32'(r_tx_pkt_cnt), CNT_WIDTH));
                        // A stop arriving with the closing flit ends the run here.
                        if (w_num_hit || r_stop_pend || w_stop_req) begin
                            w_state_nxt = DONE;
                        end
                    end else begin
                        w_idx_nxt = r_flit_idx + LEN_WIDTH'(1);
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_send_nxt = (w_state_nxt == SEND);

    always_comb begin
        w_tdata_nxt = '0;
        w_tdata_nxt[FLIT_IDX_LSB +: FLIT_IDX_W] = FLIT_IDX_W'(w_idx_nxt);
        w_tdata_nxt[SEQ_LSB +: SEQ_W]           = SEQ_W'(w_seq_nxt);
    end

    // Output flops are loaded from next-state values so every port is a flop.
    always_ff @(posedge clk_usr or negedge rst_n) begin
        if (!rst_n) begin
            r_dest       <= '0;
            r_len        <= '0;
            r_num        <= '0;
            r_flit_idx   <= '0;
            r_pkt_seq    <= '0;
            r_tx_pkt_cnt <= '0;
            r_stop_pend  <= 1'b0;
            r_tvalid     <= 1'b0;
            r_tdata      <= '0;
            r_tlast      <= 1'b0;
            r_tid        <= '0;
            r_tdest      <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_dest       <= w_dest_nxt;
            r_len        <= w_len_nxt;
            r_num        <= w_num_nxt;
            r_flit_idx   <= w_idx_nxt;
            r_pkt_seq    <= w_seq_nxt;
            r_tx_pkt_cnt <= w_cnt_nxt;
            r_stop_pend  <= w_stop_nxt;
            r_tvalid     <= w_send_nxt;
            r_tdata      <= w_send_nxt ? w_tdata_nxt : '0;
            r_tlast      <= w_send_nxt && (w_idx_nxt == (w_len_nxt - LEN_WIDTH'(1)));
            r_tid        <= w_send_nxt ? TID_WIDTH'(w_seq_nxt) : '0;
            r_tdest      <= w_send_nxt ? w_dest_nxt : '0;
            r_busy       <= w_send_nxt;
            r_done       <= (w_state_nxt == DONE);
        end
    end

    assign axis_out.tvalid = r_tvalid;
    assign axis_out.tdata  = r_tdata;
    assign axis_out.tlast  = r_tlast;
    assign axis_out.tid    = r_tid;
    assign axis_out.tdest  = r_tdest;
    assign busy            = r_busy;
    assign done            = r_done;
    assign tx_pkt_cnt      = r_tx_pkt_cnt;

    noc_ep_rx_checker #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_rx_checker (
        .clk_usr    (clk_usr),
        .rst_n      (rst_n),
        .axis_in    (axis_in),
        .rx_pkt_cnt (rx_pkt_cnt),
        .rx_err_cnt (rx_err_cnt)
    );

endmodule

`default_nettype wire

// File: tb/tb_noc_traffic_endpoint.sv
// ============================================================================
// Module      : tb_noc_traffic_endpoint
// Description : Self-checking bench for noc_traffic_endpoint (honours
//               NOC_EP_RX_CHECK_EN for the RX error expectations).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_noc_traffic_endpoint;

`ifdef NOC_EP_RX_CHECK_EN
    localparam int CHECK_EN = 1;
`else
    localparam int CHECK_EN = 0;
`endif

    logic        clk_usr = 1'b0;
    logic        rst_n   = 1'b0;
    logic        cfg_start = 1'b0;
    logic        cfg_stop  = 1'b0;
    logic [3:0]  cfg_dest  = '0;
    logic [7:0]  cfg_pkt_len  = '0;
    logic [15:0] cfg_num_pkts = '0;
    logic        busy, done;
    logic [15:0] tx_pkt_cnt, rx_pkt_cnt, rx_err_cnt;

    logic        loop_en = 1'b0;
    logic        tb_out_tready = 1'b0;
    logic        tb_in_tvalid  = 1'b0;
    logic        tb_in_tlast   = 1'b0;
    logic [31:0] tb_in_tdata   = '0;
    logic [1:0]  tb_in_tid     = '0;

    int checks  = 0;
    int errors  = 0;
    int rx_exp  = 0;
    int err_exp = 0;
    int k;

    noc_traffic_endpoint_if #(.TID_WIDTH(2), .TDEST_WIDTH(4), .TDATA_WIDTH(32)) axis_out ();
    noc_traffic_endpoint_if #(.TID_WIDTH(2), .TDEST_WIDTH(4), .TDATA_WIDTH(32)) axis_in ();

    always_comb begin
        axis_out.tready = loop_en ? axis_in.tready  : tb_out_tready;
        axis_in.tvalid  = loop_en ? axis_out.tvalid : tb_in_tvalid;
        axis_in.tdata   = loop_en ? axis_out.tdata  : tb_in_tdata;
        axis_in.tlast   = loop_en ? axis_out.tlast  : tb_in_tlast;
        axis_in.tid     = loop_en ? axis_out.tid    : tb_in_tid;
        axis_in.tdest   = loop_en ? axis_out.tdest  : 4'd0;
    end

    noc_traffic_endpoint #(
        .TID_WIDTH(2), .TDEST_WIDTH(4), .TDATA_WIDTH(32), .LEN_WIDTH(8), .CNT_WIDTH(16)
    ) dut (
        .clk_usr      (clk_usr),
        .rst_n        (rst_n),
        .cfg_start    (cfg_start),
        .cfg_stop     (cfg_stop),
        .cfg_dest     (cfg_dest),
        .cfg_pkt_len  (cfg_pkt_len),
        .cfg_num_pkts (cfg_num_pkts),
        .axis_out     (axis_out),
        .axis_in      (axis_in),
        .busy         (busy),
        .done         (done),
        .tx_pkt_cnt   (tx_pkt_cnt),
        .rx_pkt_cnt   (rx_pkt_cnt),
        .rx_err_cnt   (rx_err_cnt)
    );

    always #5 clk_usr = ~clk_usr;

    initial begin
        #5_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int sat16(input int v);
        return (v > 65535) ? 65535 : v;
    endfunction

    // Expected k-th TX flit of a run: packet k/len, index k%len.
    task automatic exp_flit(input int kk, input int len, output logic [31:0] d,
                            output logic l, output logic [1:0] id);
        int pkt, idx;
        pkt = kk / len;
        idx = kk % len;
        d   = {pkt[15:0], idx[15:0]};
        l   = (idx == len - 1);
        id  = pkt[1:0];
    endtask

    // rmode: 0 tready=1, 1 toggling, 2 random. stop_k: pulse cfg_stop while flit stop_k is offered.
    task automatic run_tx(input string tag, input logic [3:0] dest, input int len_cfg, input int num,
                          input int rmode, input int stop_k, input int exp_pkts, input int bound);
        int          elen, it, first_hs, last_hs;
        logic        tr, stalled, finished, l, hl;
        logic [31:0] d, hd;
        logic [1:0]  id, hid;
        elen = (len_cfg == 0) ? 1 : len_cfg;
        @(negedge clk_usr);
        cfg_dest     = dest;
        cfg_pkt_len  = len_cfg[7:0];
        cfg_num_pkts = num[15:0];
        cfg_start    = 1'b1;
        @(negedge clk_usr);
        cfg_start = 1'b0;
        chk({tag, "_latency_tvalid"}, axis_out.tvalid, 1);
        k = 0; it = 1; stalled = 1'b0; finished = 1'b0; first_hs = -1; last_hs = -1;
        hd = '0; hl = 1'b0; hid = '0;
        while (!finished) begin
            if (done) begin
                finished = 1'b1;
            end else if (it > bound) begin
                chk({tag, "_timeout_done"}, done, 1);
                finished = 1'b1;
            end else begin
                chk({tag, "_tvalid_held"}, axis_out.tvalid, 1);
                if (stalled) begin
                    chk({tag, "_stall_tdata"}, axis_out.tdata, hd);
                    chk({tag, "_stall_tlast"}, axis_out.tlast, hl);
                    chk({tag, "_stall_tid"},   axis_out.tid, hid);
                end
                if (loop_en)         tr = axis_in.tready;
                else if (rmode == 0) tr = 1'b1;
                else if (rmode == 1) tr = it[0];
                else                 tr = ($urandom_range(0, 1) == 1);
                tb_out_tready = tr;
                cfg_stop = (k == stop_k);
                if (axis_out.tvalid && tr) begin
                    exp_flit(k, elen, d, l, id);
                    chk({tag, "_tdata"}, axis_out.tdata, d);
                    chk({tag, "_tlast"}, axis_out.tlast, l);
                    chk({tag, "_tid"},   axis_out.tid, id);
                    chk({tag, "_tdest"}, axis_out.tdest, dest);
                    if (loop_en && axis_out.tlast) rx_exp++;
                    if (first_hs < 0) first_hs = it;
                    last_hs = it;
                    k++;
                    stalled = 1'b0;
                end else begin
                    stalled = axis_out.tvalid;
                    hd = axis_out.tdata; hl = axis_out.tlast; hid = axis_out.tid;
                end
                @(negedge clk_usr);
                it++;
            end
        end
        cfg_stop = 1'b0;
        tb_out_tready = 1'b0;
        chk({tag, "_flit_count"}, k, exp_pkts * elen);
        chk({tag, "_tx_pkt_cnt"}, tx_pkt_cnt, sat16(exp_pkts));
        chk({tag, "_done"}, done, 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_tvalid_low"}, axis_out.tvalid, 0);
        if (rmode == 0 && !loop_en) chk({tag, "_no_bubble"}, last_hs - first_hs + 1, exp_pkts * elen);
    endtask

    task automatic rx_flit(input int idx, input int seq, input logic [1:0] id, input logic last);
        tb_in_tvalid = 1'b1;
        tb_in_tdata  = {seq[15:0], idx[15:0]};
        tb_in_tid    = id;
        tb_in_tlast  = last;
        @(negedge clk_usr);
        if (last) rx_exp++;
    endtask

    initial begin
        int          n, len, seq;
        logic [3:0]  dest;
        logic [1:0]  id;

        // Reset state
        repeat (3) @(negedge clk_usr);
        chk("rst_tvalid", axis_out.tvalid, 0);
        chk("rst_tready", axis_in.tready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_cnts", {tx_pkt_cnt, rx_pkt_cnt, rx_err_cnt}, 0);
        rst_n = 1'b1;
        @(negedge clk_usr);
        chk("rel_tready", axis_in.tready, 1);

        // Fixed run, full throughput, then toggling back-pressure
        run_tx("t1", 4'd5, 4, 3, 0, -1, 3, 100);
        run_tx("t2", 4'd5, 4, 3, 1, -1, 3, 100);

        // Randomised runs
        for (int r = 0; r < 4; r++) begin
            dest = 4'($urandom_range(0, 15));
            len  = $urandom_range(1, 6);
            n    = $urandom_range(1, 4);
            run_tx("trnd", dest, len, n, 2, -1, n, 400);
        end

        // Loopback, len 0 behaves as 1, run until stop during the 10th packet
        loop_en = 1'b1;
        run_tx("t3", 4'($urandom_range(0, 15)), 0, 0, 0, 9, 10, 100);
        loop_en = 1'b0;
        chk("t3_rx_pkt_cnt", rx_pkt_cnt, sat16(rx_exp));
        chk("t3_rx_err_cnt", rx_err_cnt, err_exp);

        // Directed RX injection: skipped index, then tid change mid-packet
        rx_flit(0, 7, 2'd0, 1'b0);
        rx_flit(1, 7, 2'd0, 1'b0);
        rx_flit(3, 7, 2'd0, 1'b1);
        tb_in_tvalid = 1'b0;
        err_exp += CHECK_EN;
        @(negedge clk_usr);
        chk("t4a_rx_pkt_cnt", rx_pkt_cnt, sat16(rx_exp));
        chk("t4a_rx_err_cnt", rx_err_cnt, err_exp);
        rx_flit(0, 8, 2'd1, 1'b0);
        rx_flit(1, 8, 2'd1, 1'b0);
        rx_flit(2, 8, 2'd2, 1'b0);
        rx_flit(3, 8, 2'd1, 1'b1);
        tb_in_tvalid = 1'b0;
        err_exp += CHECK_EN;
        @(negedge clk_usr);
        chk("t4b_rx_pkt_cnt", rx_pkt_cnt, sat16(rx_exp));
        chk("t4b_rx_err_cnt", rx_err_cnt, err_exp);
        // Well-formed random packets add no errors
        for (int p = 0; p < 3; p++) begin
            len = $urandom_range(1, 5);
            id  = 2'($urandom_range(0, 3));
            seq = $urandom_range(0, 65535);
            for (int i = 0; i < len; i++) rx_flit(i, seq, id, i == len - 1);
        end
        tb_in_tvalid = 1'b0;
        @(negedge clk_usr);
        chk("t4c_rx_pkt_cnt", rx_pkt_cnt, sat16(rx_exp));
        chk("t4c_rx_err_cnt", rx_err_cnt, err_exp);

        // Asynchronous reset while flit 2 of an 8-flit packet is offered
        cfg_dest = 4'd9; cfg_pkt_len = 8'd8; cfg_num_pkts = 16'd1; cfg_start = 1'b1;
        @(negedge clk_usr);
        cfg_start = 1'b0;
        tb_out_tready = 1'b1;
        n = 0;
        while (!(axis_out.tvalid && axis_out.tdata[15:0] == 16'd2) && n < 20) begin
            @(negedge clk_usr);
            n++;
        end
        chk("t5_at_flit2", axis_out.tdata[15:0], 2);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_tvalid", axis_out.tvalid, 0);
        chk("t5_tdata", axis_out.tdata, 0);
        chk("t5_tlast_tid_tdest", {axis_out.tlast, axis_out.tid, axis_out.tdest}, 0);
        chk("t5_busy_done", {busy, done}, 0);
        chk("t5_cnts", {tx_pkt_cnt, rx_pkt_cnt, rx_err_cnt}, 0);
        chk("t5_tready", axis_in.tready, 0);
        rx_exp = 0; err_exp = 0;
        @(negedge clk_usr);
        rst_n = 1'b1;
        tb_out_tready = 1'b0;
        @(negedge clk_usr);
        chk("t5_idle", {busy, done, axis_out.tvalid}, 0);
        chk("t5_rel_tready", axis_in.tready, 1);
        run_tx("t5r", 4'd9, 2, 2, 0, -1, 2, 100);

        // Counter saturation over a long loopback run
        loop_en = 1'b1;
        run_tx("t6", 4'd3, 1, 0, 0, 65537, 65538, 70000);
        loop_en = 1'b0;
        chk("t6_tx_sat", tx_pkt_cnt, 16'hFFFF);
        chk("t6_rx_sat", rx_pkt_cnt, sat16(rx_exp));
        chk("t6_rx_err", rx_err_cnt, err_exp);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
